// File: rtl/data_mem_if.sv
// LSU data-port bus: request/grant in, one-cycle response out.
// master = LSU side, slave = memory responder side.
interface data_mem_if;
  logic        data_req;
  logic [31:0] data_addr;
  logic [3:0]  data_we;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req,
    output data_addr,
    output data_we,
    output data_wdata,
    input  data_gnt,
    input  data_rvalid,
    input  data_rdata,
    input  data_err
  );

  modport slave (
    input  data_req,
    input  data_addr,
    input  data_we,
    input  data_wdata,
    output data_gnt,
    output data_rvalid,
    output data_rdata,
    output data_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word RAM behind the LSU data port: programmable wait states,
// byte-lane writes, one-cycle response with full read word or error.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic       clk,
  input logic       rst_n,
  data_mem_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic          gnt;
  logic          accept;
  logic          access;
  logic [31:0]   acc_addr;
  logic [3:0]    acc_we;
  logic [31:0]   acc_wdata;
  logic [31:0]   acc_off;
  logic          in_range;
  logic [AW-1:0] acc_idx;

  logic [31:0] mem [DEPTH_WORDS];

  assign gnt    = rst_n & (state_q == IDLE);
  assign accept = gnt & bus.data_req;

  // With no wait states the access uses the live bus on the accept edge
  always_comb begin
    acc_addr  = addr_q;
    acc_we    = we_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_addr  = bus.data_addr;
      acc_we    = bus.data_we;
      acc_wdata = bus.data_wdata;
    end
  end

  assign acc_off  = acc_addr - BASE_ADDR;
  assign in_range = (acc_addr >= BASE_ADDR) &&
                    ((acc_off >> 2) < DEPTH_WORDS);
  assign acc_idx  = acc_off[AW+1:2];

  assign access = (accept && NO_WAIT) ||
                  (state_q == WAIT && cnt_q == 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      we_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept) state_d = NO_WAIT ? RESP : WAIT;
      end
      (state_q == WAIT): begin
        if (cnt_q == 4'd1) state_d = RESP;
      end
      (state_q == RESP): state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      cnt_d   = WAIT_LD;
      addr_d  = bus.data_addr;
      we_d    = bus.data_we;
      wdata_d = bus.data_wdata;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (access) begin
      err_d   = !in_range;
      rdata_d = 32'd0;
      if (in_range && acc_we == 4'd0) rdata_d = mem[acc_idx];
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (access && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_we[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    bus.data_gnt    = gnt;
    bus.data_rvalid = (state_q == RESP);
    bus.data_err    = (state_q == RESP) & err_q;
    bus.data_rdata  = rdata_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (1, 3, 0 wait states),
// vector table plus scoreboard queue checked by a response monitor.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3] = '{1'b0, 1'b0, 1'b0};
  logic        req   [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] addr  [3] = '{32'd0, 32'd0, 32'd0};
  logic [3:0]  we    [3] = '{4'd0, 4'd0, 4'd0};
  logic [31:0] wdata [3] = '{32'd0, 32'd0, 32'd0};
  logic        gnt   [3];
  logic        rvalid[3];
  logic [31:0] rdata [3];
  logic        err   [3];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int unsigned wcyc(int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 0;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 1 : (g == 1) ? 3 : 0;
    localparam logic [31:0] B = (g == 2) ? 32'h1000 : 32'h0;
    data_mem_if bus ();
    assign bus.data_req   = req[g];
    assign bus.data_addr  = addr[g];
    assign bus.data_we    = we[g];
    assign bus.data_wdata = wdata[g];
    assign gnt[g]    = bus.data_gnt;
    assign rvalid[g] = bus.data_rvalid;
    assign rdata[g]  = bus.data_rdata;
    assign err[g]    = bus.data_err;
    data_mem_responder #(
      .DEPTH_WORDS(1024),
      .BASE_ADDR  (B),
      .WAIT_CYCLES(W)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n[g]),
      .bus  (bus)
    );
  end

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t sbq[$];
  vec_t tv[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops the scoreboard on every rvalid
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rvalid[i] === 1'b1) begin
        if (sbq.size() == 0) begin
          check($sformatf("unexpected_rvalid_inst%0d", i), 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("resp_inst", 32'(i), 32'(e.inst));
          check("rdata", rdata[i], e.rdata);
          check("err", 32'(err[i]), 32'(e.err));
          check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end else begin
        check($sformatf("err_idle_inst%0d", i), 32'(err[i]), 32'd0);
      end
    end
  end

  task automatic issue(int i, logic [31:0] a, logic [3:0] w,
                       logic [31:0] d, logic [31:0] er, logic ee);
    int n = 0;
    @(negedge clk);
    while (gnt[i] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (gnt[i] !== 1'b1) begin
      check("gnt_timeout", 32'(gnt[i]), 32'd1);
      return;
    end
    req[i] = 1'b1; addr[i] = a; we[i] = w; wdata[i] = d;
    sbq.push_back('{inst: i, rdata: er, err: ee,
                    lat: wcyc(i) + 1, acc: cyc + 1});
    @(posedge clk);
    #1;
    req[i] = 1'b0; addr[i] = ~a; we[i] = ~w; wdata[i] = ~d;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic throughput(int i, logic [31:0] a, logic [31:0] er, int per);
    int lastc = -1;
    int pulses = 0;
    @(negedge clk);
    req[i] = 1'b1; addr[i] = a; we[i] = 4'd0; wdata[i] = 32'd0;
    for (int k = 0; k <= 3 * per; k++) begin
      if (gnt[i] === 1'b1) begin
        sbq.push_back('{inst: i, rdata: er, err: 1'b0,
                        lat: wcyc(i) + 1, acc: cyc + 1});
        if (lastc >= 0) check("gnt_period", 32'(int'(cyc) - lastc), 32'(per));
        lastc = int'(cyc);
        pulses++;
      end
      @(negedge clk);
    end
    req[i] = 1'b0;
    check("gnt_pulses", 32'(pulses), 32'd4);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1);
  end

  initial begin
    int rv_cnt;
    tv.push_back('{0, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0});
    tv.push_back('{0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0});
    tv.push_back('{0, 32'h0000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0});
    tv.push_back('{0, 32'h0000_0004, 4'hF, 32'h1122_3344, 32'h0, 1'b0});
    tv.push_back('{0, 32'h0000_0005, 4'h2, 32'h0000_AB00, 32'h0, 1'b0});
    tv.push_back('{0, 32'h0000_0004, 4'h0, 32'h0, 32'h1122_AB44, 1'b0});
    tv.push_back('{0, 32'h0000_0006, 4'hC, 32'hCAFE_0000, 32'h0, 1'b0});
    tv.push_back('{0, 32'h0000_0004, 4'h0, 32'h0, 32'hCAFE_AB44, 1'b0});
    tv.push_back('{0, 32'h0000_1000, 4'h0, 32'h0, 32'h0, 1'b1});
    tv.push_back('{0, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1});
    tv.push_back('{0, 32'h0000_0000, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0});
    tv.push_back('{0, 32'h0000_0FFC, 4'hF, 32'h1234_5678, 32'h0, 1'b0});
    tv.push_back('{0, 32'h0000_0FFF, 4'h0, 32'h0, 32'h1234_5678, 1'b0});
    tv.push_back('{0, 32'hFFFF_FFFC, 4'h0, 32'h0, 32'h0, 1'b1});
    tv.push_back('{0, 32'h0000_0004, 4'h1, 32'h0000_00EE, 32'h0, 1'b0});
    tv.push_back('{0, 32'h0000_0004, 4'h0, 32'h0, 32'hCAFE_ABEE, 1'b0});
    tv.push_back('{2, 32'h0000_1000, 4'hF, 32'hA5A5_A5A5, 32'h0, 1'b0});
    tv.push_back('{2, 32'h0000_1000, 4'h0, 32'h0, 32'hA5A5_A5A5, 1'b0});
    tv.push_back('{2, 32'h0000_0FFC, 4'h0, 32'h0, 32'h0, 1'b1});
    tv.push_back('{2, 32'h0000_1FFC, 4'hF, 32'h0102_0304, 32'h0, 1'b0});
    tv.push_back('{2, 32'h0000_1FFC, 4'h0, 32'h0, 32'h0102_0304, 1'b0});
    tv.push_back('{2, 32'h0000_2000, 4'h0, 32'h0, 32'h0, 1'b1});
    tv.push_back('{2, 32'h0000_0000, 4'h0, 32'h0, 32'h0, 1'b1});
    tv.push_back('{1, 32'h0000_0008, 4'hF, 32'h0000_0000, 32'h0, 1'b0});
    tv.push_back('{1, 32'h0000_0008, 4'h0, 32'h0, 32'h0, 1'b0});
    tv.push_back('{1, 32'h0000_000C, 4'hF, 32'h7777_7777, 32'h0, 1'b0});
    tv.push_back('{1, 32'h0000_000C, 4'h0, 32'h0, 32'h7777_7777, 1'b0});

    // Reset state
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_gnt%0d", i), 32'(gnt[i]), 32'd0);
      check($sformatf("rst_rvalid%0d", i), 32'(rvalid[i]), 32'd0);
      check($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
    end
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post_rst_gnt%0d", i), 32'(gnt[i]), 32'd1);
      check($sformatf("post_rst_rvalid%0d", i), 32'(rvalid[i]), 32'd0);
    end

    // Vector table
    foreach (tv[k]) begin
      if (k > 0 && tv[k].inst != tv[k-1].inst) drain();
      issue(tv[k].inst, tv[k].addr, tv[k].we, tv[k].wdata,
            tv[k].rdata, tv[k].err);
    end
    drain();

    // Back-to-back requests: grant every W+2 cycles
    throughput(1, 32'h0000_000C, 32'h7777_7777, 5);
    throughput(2, 32'h0000_1000, 32'hA5A5_A5A5, 2);
    throughput(0, 32'h0000_0010, 32'hDEAD_BEEF, 3);

    // Reset in the middle of a waiting write discards it
    @(negedge clk);
    req[1] = 1'b1; addr[1] = 32'h8; we[1] = 4'hF; wdata[1] = 32'h55;
    check("midrst_gnt_before", 32'(gnt[1]), 32'd1);
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    check("midrst_gnt_low", 32'(gnt[1]), 32'd0);
    check("midrst_rvalid_low", 32'(rvalid[1]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    rv_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rvalid[1] === 1'b1) rv_cnt++;
    end
    check("midrst_no_resp", 32'(rv_cnt), 32'd0);
    check("midrst_gnt_after", 32'(gnt[1]), 32'd1);
    issue(1, 32'h0000_0008, 4'h0, 32'h0, 32'h0, 1'b0);
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the load/store unit's data port. Accepts the LSU's byte-addressed word requests (data_addr, lane-aligned data_wdata, 4-bit data_we byte enables), performs the access on an internal word-organised RAM after a programmable number of wait states, and returns a one-cycle response with the full read word or an error flag. It sits between the core's data port and the data RAM, and is the reference slave for LSU and core-level benches.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM (power of two, 16..65536)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to DEPTH_WORDS*4)
WAIT_CYCLES, 1, wait states between acceptance and access (0..15)

Ports:
clk  in  1  system clock, all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
data_req  in  1  request valid from LSU
data_addr  in  32  byte address; bits [1:0] ignored (lane selection via data_we)
data_we  in  4  byte write enables; 4'b0000 = read
data_wdata  in  32  lane-aligned write data
data_gnt  out  1  request accepted this cycle when data_req & data_gnt
data_rvalid  out  1  one-cycle response strobe
data_rdata  out  32  read word (valid with data_rvalid)
data_err  out  1  access error (valid with data_rvalid, else 0)

Behaviour:
- Reset (rst_n low, async): state IDLE, wait counter 0, data_gnt=0, data_rvalid=0, data_err=0, data_rdata=0. RAM contents not reset.
- data_gnt = rst_n & (state==IDLE); combinational from state.
- FSM states IDLE, WAIT, RESP.
- IDLE: on edge with data_req=1, latch addr, we, wdata; counter <= WAIT_CYCLES; go WAIT if WAIT_CYCLES>0, else perform access on that same edge and go RESP.
- WAIT: counter decrements each edge; on the edge where counter==1, perform access, go RESP.
- Access: index = (addr - BASE_ADDR) >> 2, computed on 32-bit unsigned. In range iff addr >= BASE_ADDR and index < DEPTH_WORDS.
  - In range, we!=0: write byte lane i of wdata where we[i]=1; other lanes unchanged; data_rdata <= 0.
  - In range, we==0: data_rdata <= RAM[index] (full word, no extraction or sign extension).
  - Out of range: no RAM write, data_rdata <= 0, err flag set.
- RESP: data_rvalid=1, data_err=flag, for exactly one cycle; next edge -> IDLE. data_rdata holds its value until the next response.
- Latency: request accepted at edge N -> data_rvalid high in cycle after edge N+WAIT_CYCLES (WAIT_CYCLES=0: cycle immediately after acceptance).
- Throughput: one transaction per WAIT_CYCLES+2 cycles; data_gnt low in WAIT and RESP; data_req held during those cycles is ignored, not queued.
- Read after write: write completed in transaction k is visible to a read in transaction k+1.
- Changes on data_addr/data_we/data_wdata after acceptance have no effect on the latched transaction.
- Reset mid-operation: transaction discarded; a write not yet performed is never performed; no response issued.

Test Plan:
- Reset then release: all outputs 0 during reset; data_gnt=1 first cycle after release; data_rvalid=0 until a request is accepted.
- WAIT_CYCLES=1: write addr 0x10, we=1111, wdata 0xDEADBEEF; read 0x10 -> data_rvalid exactly 2 cycles after acceptance, data_rdata=0xDEADBEEF, data_err=0.
- Byte/halfword lanes: preload 0x11223344 at 0x4; write we=0010 wdata 0x0000AB00 -> read 0x1122AB44; write we=1100 wdata 0xCAFE0000 to 0x6 -> read 0xCAFEAB44.
- Out of range (DEPTH_WORDS=1024): read 0x1000 -> data_err=1, data_rdata=0; write 0x1000 then read 0x0 -> word 0 unchanged; data_err=0 outside data_rvalid.
- WAIT_CYCLES=3 and 0: measure acceptance-to-rvalid = 4 and 1 cycles; data_req held high continuously -> data_gnt pulses once every 5 and 2 cycles.
- Reset mid-WAIT: WAIT_CYCLES=3, write 0x55 to 0x8 (prev 0x0), assert rst_n low after 1 wait cycle -> no data_rvalid; read 0x8 afterwards returns 0x00000000.
